// File: rtl/i2c_pkg.sv
// Shared I2C datapath definitions: transfer-sequencer state encoding,
// the default data-bit count and the helper that sizes the bit index.
package i2c_pkg;

    // Sequencer states: waiting, shifting data bits, or in the ACK/NACK slot.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } xfer_state_t;

    // Standard I2C byte: eight data bits followed by one ACK slot.
    localparam int I2C_DATA_BITS = 8;

    // Supported range for the per-byte data-bit count.
    localparam int I2C_DATA_BITS_MIN = 2;
    localparam int I2C_DATA_BITS_MAX = 15;

    // Width needed to hold a bit index 0..data_bits-1 (at least one bit).
    function automatic int bit_w_for(input int data_bits);
        return (data_bits < 2) ? 1 : $clog2(data_bits);
    endfunction

    // Bit-index width of the default build.
    localparam int I2C_BIT_W = bit_w_for(I2C_DATA_BITS);

endpackage

// File: rtl/i2c_xfer_counter_if.sv
// Control/status bundle between the I2C master FSM and the transfer counter.
// The master drives the requests and strobes; the counter reports progress.
interface i2c_xfer_counter_if
    import i2c_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int BIT_W = I2C_BIT_W
);

    // Requests and strobes from the master side.
    logic             start;
    logic [LEN_W-1:0] len;
    logic             bit_tick;
    logic             nack_in;
    logic             abort;

    // Progress and events reported by the counter.
    logic             busy;
    logic             data_phase;
    logic             ack_phase;
    logic [BIT_W-1:0] bit_idx;
    logic [LEN_W-1:0] bytes_left;
    logic             last_byte;
    logic             byte_done;
    logic             xfer_done;
    logic             nacked;

    modport master (
        output start, len, bit_tick, nack_in, abort,
        input  busy, data_phase, ack_phase, bit_idx, bytes_left,
               last_byte, byte_done, xfer_done, nacked
    );

    modport slave (
        input  start, len, bit_tick, nack_in, abort,
        output busy, data_phase, ack_phase, bit_idx, bytes_left,
               last_byte, byte_done, xfer_done, nacked
    );

endinterface

// File: rtl/i2c_bit_slot_counter.sv
// Modulo-MODULUS slot counter with enable, synchronous clear and a terminal
// flag. Generalisation of the fixed 8-bit detect counter: the count walks
// 0..MODULUS-1 and wraps straight back to 0, never visiting unused codes.
module i2c_bit_slot_counter #(
    parameter int MODULUS = 8,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] LAST_CODE = CNT_W'(MODULUS - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST_CODE);

    // Count enabled slots; clear wins over enable, terminal slot wraps to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_at_last;

endmodule

// File: rtl/i2c_xfer_counter.sv
// I2C transfer sequencer counter. Tracks the data-bit slot inside each byte,
// the ACK/NACK slot after it and the bytes still to go, advancing only on
// bit_tick. Reports byte-done, last-byte and transfer-done to the master FSM.
// Every output is a register so the master sees clean, glitch-free levels.
module i2c_xfer_counter
    import i2c_pkg::*;
#(
    parameter  int DATA_BITS = I2C_DATA_BITS,  // 2..15 data bits per byte
    parameter  int LEN_W     = 8,
    localparam int BIT_W     = bit_w_for(DATA_BITS)
) (
    input  logic              clk,
    input  logic              reset_n,
    i2c_xfer_counter_if.slave bus
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    xfer_state_t      r_state;
    xfer_state_t      w_state_next;

    logic [LEN_W-1:0] r_bytes_left;
    logic [LEN_W-1:0] w_bytes_left_next;
    logic             r_busy,       w_busy_next;
    logic             r_data_phase, w_data_phase_next;
    logic             r_ack_phase,  w_ack_phase_next;
    logic             r_last_byte,  w_last_byte_next;
    logic             r_byte_done,  w_byte_done_next;
    logic             r_xfer_done,  w_xfer_done_next;
    logic             r_nacked,     w_nacked_next;

    // ------------------------------------------------------------------
    // Qualified events
    // ------------------------------------------------------------------
    logic             w_accept;     // start taken (only possible when idle)
    logic             w_abort;      // abort only means something when busy
    logic             w_tick;       // tick that survives abort priority
    logic             w_len_nz;
    logic             w_bytes_one;
    logic             w_ack_tick;   // tick landing in the ACK slot
    logic             w_bit_en;
    logic             w_bit_clr;
    logic [BIT_W-1:0] w_bit_idx;
    logic             w_bit_last;

    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_abort     = (r_state != IDLE) && bus.abort;
    assign w_tick      = bus.bit_tick && !bus.abort;
    assign w_len_nz    = |bus.len;
    assign w_bytes_one = (r_bytes_left == LEN_W'(1));
    assign w_ack_tick  = (r_state == ACK) && w_tick;

    // Bit slot counter only advances in DATA; an accepted start or an abort
    // returns it to the first (MSB) slot. Leaving DATA on the terminal tick
    // wraps it to 0, which is the value shown during the ACK slot.
    assign w_bit_en  = (r_state == DATA) && w_tick;
    assign w_bit_clr = w_abort || w_accept;

    i2c_bit_slot_counter #(
        .MODULUS (DATA_BITS),
        .CNT_W   (BIT_W)
    ) u_bit_slot_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_bit_en),
        .i_clr      (w_bit_clr),
        .o_count    (w_bit_idx),
        .o_terminal (w_bit_last)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: abort beats a coincident tick; NACK or last ACK ends it.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start && w_len_nz) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_tick && w_bit_last) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_tick) begin
                    if (bus.nack_in || w_bytes_one) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the current state,
    // the qualified events and the next state.
    always_comb begin
        w_bytes_left_next = r_bytes_left;
        w_byte_done_next  = 1'b0;
        w_xfer_done_next  = 1'b0;
        w_nacked_next     = r_nacked;

        if (w_accept) begin
            // A zero-length request completes immediately without going busy.
            w_bytes_left_next = bus.len;
            w_nacked_next     = 1'b0;
            w_xfer_done_next  = !w_len_nz;
        end else if (w_ack_tick) begin
            w_byte_done_next = 1'b1;
            if (bus.nack_in) begin
                // Remaining count is left intact so firmware can see how far
                // the transfer got before the slave refused.
                w_xfer_done_next = 1'b1;
                w_nacked_next    = 1'b1;
            end else if (w_bytes_one) begin
                w_xfer_done_next  = 1'b1;
                w_bytes_left_next = '0;
            end else if (r_bytes_left != '0) begin
                w_bytes_left_next = r_bytes_left - LEN_W'(1);
            end
        end

        w_busy_next       = (w_state_next != IDLE);
        w_data_phase_next = (w_state_next == DATA);
        w_ack_phase_next  = (w_state_next == ACK);
        w_last_byte_next  = w_busy_next && (w_bytes_left_next == LEN_W'(1));
    end

    // Output registers; reset forces all status and pulses low immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bytes_left <= '0;
            r_busy       <= 1'b0;
            r_data_phase <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_last_byte  <= 1'b0;
            r_byte_done  <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_nacked     <= 1'b0;
        end else begin
            r_bytes_left <= w_bytes_left_next;
            r_busy       <= w_busy_next;
            r_data_phase <= w_data_phase_next;
            r_ack_phase  <= w_ack_phase_next;
            r_last_byte  <= w_last_byte_next;
            r_byte_done  <= w_byte_done_next;
            r_xfer_done  <= w_xfer_done_next;
            r_nacked     <= w_nacked_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy       = r_busy;
    assign bus.data_phase = r_data_phase;
    assign bus.ack_phase  = r_ack_phase;
    assign bus.bit_idx    = w_bit_idx;
    assign bus.bytes_left = r_bytes_left;
    assign bus.last_byte  = r_last_byte;
    assign bus.byte_done  = r_byte_done;
    assign bus.xfer_done  = r_xfer_done;
    assign bus.nacked     = r_nacked;

endmodule

// File: tb/tb_i2c_xfer_counter.sv
// Self-checking bench for i2c_xfer_counter: a vector table for the basic
// single-byte flow plus hand sequences for multi-byte, NACK, abort, reset and
// a DATA_BITS=4 build. Expected outputs go into a scoreboard queue when the
// stimulus is driven and are popped and compared one edge later.
`timescale 1ns/1ps
module tb_i2c_xfer_counter;
    import i2c_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       data_phase;
        logic       ack_phase;
        logic [3:0] bit_idx;
        logic [7:0] bytes_left;
        logic       last_byte;
        logic       byte_done;
        logic       xfer_done;
        logic       nacked;
    } exp_t;

    typedef struct {
        int    dut;
        exp_t  exp;
        string name;
    } sb_t;

    typedef struct {
        string name;
        logic  start;
        int    len;
        logic  tick;
        logic  nack;
        logic  abort;
        exp_t  exp;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    sb_t  sb_q[$];
    vec_t vecs[0:23];
    int   n_vecs = 0;

    always #5 clk = ~clk;

    i2c_xfer_counter_if #(.LEN_W(8), .BIT_W(3)) bus_a ();
    i2c_xfer_counter_if #(.LEN_W(8), .BIT_W(2)) bus_b ();

    i2c_xfer_counter #(.DATA_BITS(8), .LEN_W(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    i2c_xfer_counter #(.DATA_BITS(4), .LEN_W(8)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    function automatic exp_t mk(bit b, bit dp, bit ap, int bi, int bl,
                                bit lb, bit bd, bit xd, bit nk);
        exp_t e;
        e.busy       = b;
        e.data_phase = dp;
        e.ack_phase  = ap;
        e.bit_idx    = 4'(bi);
        e.bytes_left = 8'(bl);
        e.last_byte  = lb;
        e.byte_done  = bd;
        e.xfer_done  = xd;
        e.nacked     = nk;
        return e;
    endfunction

    // Expected outputs after the k-th tick (k>=1) of an n-byte transfer of
    // db-bit bytes: each byte is db data slots then one ACK slot.
    function automatic exp_t after_tick(int k, int n, int db);
        int q;
        int p;
        int left;
        q    = k / (db + 1);
        p    = k % (db + 1);
        left = n - q;
        if (p == 0) begin
            if (q == n) return mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
            return mk(1, 1, 0, 0, left, left == 1, 1, 0, 0);
        end
        if (p < db) return mk(1, 1, 0, p, left, left == 1, 0, 0, 0);
        return mk(1, 0, 1, 0, left, left == 1, 0, 0, 0);
    endfunction

    function automatic exp_t sample(int d);
        exp_t e;
        if (d == 0) begin
            e.busy       = bus_a.busy;
            e.data_phase = bus_a.data_phase;
            e.ack_phase  = bus_a.ack_phase;
            e.bit_idx    = 4'(bus_a.bit_idx);
            e.bytes_left = bus_a.bytes_left;
            e.last_byte  = bus_a.last_byte;
            e.byte_done  = bus_a.byte_done;
            e.xfer_done  = bus_a.xfer_done;
            e.nacked     = bus_a.nacked;
        end else begin
            e.busy       = bus_b.busy;
            e.data_phase = bus_b.data_phase;
            e.ack_phase  = bus_b.ack_phase;
            e.bit_idx    = 4'(bus_b.bit_idx);
            e.bytes_left = bus_b.bytes_left;
            e.last_byte  = bus_b.last_byte;
            e.byte_done  = bus_b.byte_done;
            e.xfer_done  = bus_b.xfer_done;
            e.nacked     = bus_b.nacked;
        end
        return e;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("busy=%0b dp=%0b ap=%0b idx=%0d left=%0d last=%0b bd=%0b xd=%0b nk=%0b",
                         e.busy, e.data_phase, e.ack_phase, e.bit_idx, e.bytes_left,
                         e.last_byte, e.byte_done, e.xfer_done, e.nacked);
    endfunction

    task automatic compare_front();
        sb_t  s;
        exp_t act;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        s   = sb_q.pop_front();
        act = sample(s.dut);
        if (act !== s.exp) begin
            failures++;
            $display("FAIL %s dut%0d: got {%s} required {%s}", s.name, s.dut, fmt(act), fmt(s.exp));
        end else begin
            $display("ok   %s dut%0d: {%s}", s.name, s.dut, fmt(act));
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic drive(int d, logic st, int ln, logic tk, logic nk, logic ab);
        bus_a.start = 1'b0; bus_a.len = '0; bus_a.bit_tick = 1'b0;
        bus_a.nack_in = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.len = '0; bus_b.bit_tick = 1'b0;
        bus_b.nack_in = 1'b0; bus_b.abort = 1'b0;
        if (d == 0) begin
            bus_a.start = st; bus_a.len = 8'(ln); bus_a.bit_tick = tk;
            bus_a.nack_in = nk; bus_a.abort = ab;
        end else begin
            bus_b.start = st; bus_b.len = 8'(ln); bus_b.bit_tick = tk;
            bus_b.nack_in = nk; bus_b.abort = ab;
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(int d, string name, logic st, int ln, logic tk, logic nk,
                        logic ab, exp_t e);
        drive(d, st, ln, tk, nk, ab);
        sb_q.push_back('{dut: d, exp: e, name: name});
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic add_vec(string name, logic st, int ln, logic tk, logic nk,
                           logic ab, exp_t e);
        vecs[n_vecs] = '{name: name, start: st, len: ln, tick: tk, nack: nk,
                         abort: ab, exp: e};
        n_vecs++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bd_cnt;
        int xd_cnt;

        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back('{dut: 0, exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0), name: "reset_a"});
        compare_front();
        sb_q.push_back('{dut: 1, exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0), name: "reset_b"});
        compare_front();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- vector table: idle corners and a one-byte transfer
        add_vec("idle",             0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_vec("tick_in_idle",     0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_vec("start_len0",       1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        add_vec("after_len0",       0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_vec("start1_abort_idle", 1, 1, 0, 0, 1, mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            add_vec($sformatf("len1_tick%0d", k), 0, 0, 1, 0, 0, mk(1, 1, 0, k, 1, 1, 0, 0, 0));
        add_vec("start_while_busy", 1, 5, 0, 0, 0, mk(1, 1, 0, 3, 1, 1, 0, 0, 0));
        for (int k = 4; k <= 7; k++)
            add_vec($sformatf("len1_tick%0d", k), 0, 0, 1, 0, 0, mk(1, 1, 0, k, 1, 1, 0, 0, 0));
        add_vec("len1_tick8_ack",   0, 0, 1, 0, 0, mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
        add_vec("ack_no_tick",      0, 0, 0, 0, 0, mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
        add_vec("len1_tick9_done",  0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        add_vec("after_done",       0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < n_vecs; i++)
            step(0, vecs[i].name, vecs[i].start, vecs[i].len, vecs[i].tick,
                 vecs[i].nack, vecs[i].abort, vecs[i].exp);

        // ---------------- three bytes, back-to-back ticks
        step(0, "len3_start", 1, 3, 0, 0, 0, mk(1, 1, 0, 0, 3, 0, 0, 0, 0));
        bd_cnt = 0;
        xd_cnt = 0;
        for (int k = 1; k <= 27; k++) begin
            step(0, $sformatf("len3_tick%0d", k), 0, 0, 1, 0, 0, after_tick(k, 3, 8));
            bd_cnt += int'(bus_a.byte_done);
            xd_cnt += int'(bus_a.xfer_done);
        end
        check_int("len3_byte_done_count", bd_cnt, 3);
        check_int("len3_xfer_done_count", xd_cnt, 1);

        // ---------------- NACK at byte 2, started with no gap cycle
        step(0, "len4_start", 1, 4, 0, 0, 0, mk(1, 1, 0, 0, 4, 0, 0, 0, 0));
        for (int k = 1; k <= 17; k++)
            step(0, $sformatf("len4_tick%0d", k), 0, 0, 1, (k % 9) != 0, 0, after_tick(k, 4, 8));
        step(0, "len4_nack",        0, 0, 1, 1, 0, mk(0, 0, 0, 0, 3, 0, 1, 1, 1));
        step(0, "nack_hold",        0, 0, 0, 0, 0, mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
        step(0, "nack_idle_tick",   0, 0, 1, 1, 0, mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
        step(0, "restart_clears",   1, 1, 0, 0, 0, mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        step(0, "restart_abort",    0, 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0));

        // ---------------- abort mid-byte and in the ACK slot
        step(0, "len2_start", 1, 2, 0, 0, 0, mk(1, 1, 0, 0, 2, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            step(0, $sformatf("len2_tick%0d", k), 0, 0, 1, 0, 0, after_tick(k, 2, 8));
        step(0, "abort_over_tick",  0, 0, 1, 0, 1, mk(0, 0, 0, 0, 2, 0, 0, 0, 0));
        step(0, "start_with_abort", 1, 2, 0, 0, 1, mk(1, 1, 0, 0, 2, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            step(0, $sformatf("len2b_tick%0d", k), 0, 0, 1, 0, 0, after_tick(k, 2, 8));
        step(0, "abort_in_ack",     0, 0, 1, 1, 1, mk(0, 0, 0, 0, 2, 0, 0, 0, 0));

        // ---------------- asynchronous reset mid-byte
        step(0, "rst_start", 1, 2, 0, 0, 0, mk(1, 1, 0, 0, 2, 0, 0, 0, 0));
        for (int k = 1; k <= 6; k++)
            step(0, $sformatf("rst_tick%0d", k), 0, 0, 1, 0, 0, after_tick(k, 2, 8));
        drive(0, 0, 0, 1, 0, 0);
        reset_n = 1'b0;
        #1;
        sb_q.push_back('{dut: 0, exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0), name: "rst_immediate"});
        compare_front();
        step(0, "rst_held_start", 1, 3, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, "rst_no_pulse",     0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---------------- DATA_BITS=4 build: two bytes in ten ticks
        step(1, "b_start", 1, 2, 0, 0, 0, mk(1, 1, 0, 0, 2, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++)
            step(1, $sformatf("b_tick%0d", k), 0, 0, 1, 0, 0, after_tick(k, 2, 4));
        step(1, "b_idle",           0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_xfer_counter.md
# i2c_xfer_counter

Parametrised transfer sequencer counter for the I2C master datapath. It tracks the bit position within each byte, the ACK/NACK slot after each byte, and the number of bytes remaining in a multi-byte transfer. It reports byte-done, last-byte and transfer-done events to the master FSM. It advances only on `bit_tick` pulses from the SCL generator, and aborts cleanly on NACK or on an external abort.

## Interface
- `DATA_BITS`, default 8: data bits per byte before the ACK slot; legal range 2..15.
- `LEN_W`, default 8: width of the byte-length field; the maximum transfer is 2^LEN_W−1 bytes.
- `BIT_W`, default $clog2(DATA_BITS): width of `bit_idx`; derived, not overridden.
- `clk` input 1: clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to begin a transfer; sampled only when idle.
- `len` input LEN_W: byte count, captured on an accepted `start`.
- `bit_tick` input 1: one-cycle advance strobe, one per SCL bit period.
- `nack_in` input 1: ACK-slot line value; 1 means NACK; sampled only on `bit_tick` in ACK.
- `abort` input 1: synchronous cancel of the current transfer.
- `busy` output 1: transfer in progress.
- `data_phase` output 1: currently in a data-bit slot.
- `ack_phase` output 1: currently in the ACK slot.
- `bit_idx` output BIT_W: index of the current data bit, 0 = first (MSB) bit.
- `bytes_left` output LEN_W: bytes remaining, including the current byte.
- `last_byte` output 1: `bytes_left == 1` while busy.
- `byte_done` output 1: one-cycle pulse when a byte's ACK slot completes.
- `xfer_done` output 1: one-cycle pulse when the transfer completes normally or by NACK.
- `nacked` output 1: sticky; set by a NACK-terminated transfer, cleared by the next accepted `start`.

## Operation
- States are IDLE, DATA and ACK. All outputs are registered.
- **Reset:** state IDLE; `bit_idx`=0; `bytes_left`=0. `busy`, `data_phase`, `ack_phase`, `last_byte`, `byte_done`, `xfer_done` and `nacked` are all 0.
- **IDLE, `start`=1, `len`≠0:**
  - Next cycle: DATA, `busy`=1, `bit_idx`=0, `bytes_left`=`len`, `nacked`=0.
- **IDLE, `start`=1, `len`=0:**
  - Stay IDLE; `xfer_done` pulses next cycle; `nacked` cleared.
- **DATA:** each `bit_tick` increments `bit_idx`. A tick at `bit_idx`=DATA_BITS−1 moves to ACK and sets `bit_idx` to 0.
- **ACK, `bit_tick`, `nack_in`=0:**
  - `byte_done` pulses.
  - If `bytes_left`=1: go to IDLE, pulse `xfer_done`, set `bytes_left` to 0.
  - Otherwise: decrement `bytes_left` and return to DATA.
- **ACK, `bit_tick`, `nack_in`=1:**
  - Pulse `byte_done` and `xfer_done`; set `nacked`=1.
  - Go to IDLE with `bytes_left` unchanged, so firmware can read the remaining count.
- **`abort`=1 while busy:**
  - Next cycle: IDLE, `bit_idx`=0. No `byte_done`, `xfer_done` or `nacked` change.
  - `bytes_left` is held for diagnosis.
- **Priority:** `abort` > `bit_tick`.
  - `start` while busy is ignored.
  - `abort` in IDLE is ignored, so `start` in the same cycle is accepted.
- `bit_tick` in IDLE is ignored. Ticks are never queued.
- **Arithmetic:** `bit_idx` never exceeds DATA_BITS−1 and never wraps through unused codes. `bytes_left` never underflows.
- **Phase decode:** `data_phase` = (state==DATA); `ack_phase` = (state==ACK); `last_byte` = busy && `bytes_left`==1.

## Timing
- Start-to-busy latency: 1 cycle.
- Tick-to-output latency: 1 cycle; every output updates on the edge that samples `bit_tick`.
- Byte duration: exactly DATA_BITS+1 ticks. A full N-byte transfer takes N·(DATA_BITS+1) ticks.
- `byte_done` and `xfer_done` are high for exactly one cycle. For the final byte they coincide.
- `busy` falls in the same cycle that `xfer_done` rises.
- A new `start` is accepted the cycle after `busy` falls. Back-to-back transfers need no gap cycle.
- Assertion of `reset_n` mid-transfer forces the reset values immediately. No pulse is emitted.
- Back-to-back ticks, one per clock, are legal and must be counted without loss.

## Structure
- Shared package `i2c_pkg`:
  - state enum `xfer_state_t` (IDLE, DATA, ACK);
  - constant `I2C_DATA_BITS`=8;
  - localparam helpers for BIT_W.
- One natural sub-module: `i2c_bit_slot_counter`, a modulo-(DATA_BITS) counter with enable and synchronous clear, plus a terminal flag. It generalises the team's 8-bit detect counter. Byte counting and the FSM stay in the top module.

## Test plan
- `len`=1, 9 ticks, `nack_in`=0 → `bit_idx` steps 0..7; `ack_phase` appears on tick 8; `byte_done` and `xfer_done` pulse together on tick 9; `busy`=0.
- `len`=3, 27 ticks → 3 `byte_done` pulses. `bytes_left` goes 3→2→1→0. `last_byte` is high during byte 3 only, and there is one `xfer_done`.
- `len`=4, `nack_in`=1 at the ACK of byte 2 → `xfer_done` and `nacked`=1 after 18 ticks; `bytes_left`=3; then `start` with `len`=1 clears `nacked`.
- `len`=2, `abort` after 5 ticks (`bit_idx`=5) → IDLE next cycle, no `xfer_done`, `bytes_left`=2. A `start` in the same cycle as a second `abort` is accepted.
- `len`=0 `start` → `xfer_done` pulse one cycle later with `busy` never set. A `start` while busy and ticks while idle cause no change.
- `reset_n` low at `bit_idx`=6 of byte 1 with `len`=2 → all outputs return to their reset values immediately with no pulse. The DATA_BITS=4 build completes a 2-byte transfer in 10 ticks.
